i2s_tx_fifo: RTL and testbench
==============================

I2S_TX_FIFO -- requirements
Module: i2s_tx_fifo

Interface
REQ-001 The parameter list SHALL be: CLOCKS, default 64, bit clocks per stereo frame; legal values 32 or 64 only.
REQ-002 The parameter list SHALL be: DEPTH, default 8, stereo-pair FIFO entries; power of two, 2..64.
REQ-003 The ports SHALL be:
  ck  in  1  single system clock, all logic on rising edge
  rst_n  in  1  asynchronous active-low reset
  en  in  1  bit-clock enable, same strobe that drives the downstream serialiser
  frame_posn  in  6  frame slot counter shared with the serialiser
  in_valid  in  1  producer has a stereo pair
  in_ready  out  1  FIFO can accept a pair
  in_left  in  16  producer left sample
  in_right  in  16  producer right sample
  left  out  16  left sample presented to the serialiser
  right  out  16  right sample presented to the serialiser
  level  out  $clog2(DEPTH)+1  entries currently stored
  underrun  out  1  one-cycle pulse when a frame found the FIFO empty
  underrun_count  out  8  saturating count of underruns
  clr_count  in  1  synchronous clear of underrun_count

Function
REQ-004 MASK SHALL be 6'h3F for CLOCKS=64 and 6'h1F for CLOCKS=32; frame = frame_posn & MASK.
REQ-005 A frame tick SHALL occur on any cycle with en=1 and frame==MASK, the last slot before slot 0.
REQ-006 in_ready SHALL equal (level != DEPTH), combinationally from registered state only.
REQ-007 A push SHALL occur when in_valid && in_ready; {in_left,in_right} is written at the write pointer; the write pointer advances modulo DEPTH.
REQ-008 On a frame tick with level>0: left/right SHALL load the head entry on that edge; the read pointer SHALL advance modulo DEPTH.
REQ-009 On a frame tick with level==0: left/right SHALL load 16'h0000 (mute); underrun SHALL pulse high for exactly one cycle; underrun_count SHALL increment, saturating at 8'hFF.
REQ-010 left/right SHALL change only on a frame tick or on reset, so they are stable throughout slots 0..MASK of the following frame.
REQ-011 A simultaneous push and pop SHALL leave level unchanged; push-only SHALL give +1; pop-only SHALL give -1.
REQ-012 Full case: a push SHALL never occur while level==DEPTH, even on a pop cycle; in_ready rises the cycle after the pop.
REQ-013 Empty case: a push on the same cycle as an empty frame tick SHALL be stored and SHALL NOT bypass to left/right; that tick is an underrun.
REQ-014 The FIFO SHALL provide no fall-through; data pushed becomes audible no earlier than the next frame tick.
REQ-015 clr_count=1 SHALL zero underrun_count on the next edge and SHALL take priority over a simultaneous increment.
REQ-016 en=0 SHALL suppress frame ticks regardless of frame_posn; pushes SHALL be unaffected by en.
REQ-017 frame_posn bits above MASK SHALL be ignored.

Reset
REQ-018 When rst_n is low, the block SHALL asynchronously clear the pointers, level=0, left=0, right=0, underrun=0 and underrun_count=0; in_ready=1 follows.
REQ-019 Reset asserted mid-frame SHALL discard all stored entries; the first tick after release with no pushes SHALL be an underrun.
REQ-020 Release SHALL be synchronous to ck; no push or tick SHALL be acted on in the cycle rst_n rises.

Verification
REQ-021 Reset, DEPTH=8, push (16'h1111,16'h2222), tick -> left=16'h1111, right=16'h2222, level=0, no underrun.
REQ-022 Push 8 pairs without ticks -> level=8, in_ready=0; 9th in_valid is not accepted; one tick -> level=7, in_ready=1 next cycle, left=first pair.
REQ-023 Tick with empty FIFO -> left=right=0, underrun high one cycle, underrun_count=1; 300 such ticks -> count=8'hFF.
REQ-024 Empty FIFO, push coincident with tick -> underrun pulses, outputs 0, level=1; next tick outputs the pushed pair.
REQ-025 CLOCKS=32, frame_posn=6'h3F with en=1 -> tick; frame_posn=6'h1F with en=0 -> no tick.
REQ-026 Push 3 pairs, assert rst_n low mid-frame -> all outputs 0, level=0; next tick after release -> underrun.

Source files
------------

// File: rtl/i2s_tx_fifo.sv
// Stereo-pair FIFO between a sample producer and an I2S serialiser.
// A new pair is presented on left/right once per frame, at the frame tick.
module i2s_tx_fifo #(
  parameter int CLOCKS = 64,
  parameter int DEPTH  = 8
) (
  input  logic                     ck,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [5:0]               frame_posn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [15:0]              in_left,
  input  logic [15:0]              in_right,
  output logic [15:0]              left,
  output logic [15:0]              right,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     underrun,
  output logic [7:0]               underrun_count,
  input  logic                     clr_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [5:0] MASK = (CLOCKS == 32) ? 6'h1F : 6'h3F;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          frame_tick;
  logic          empty;
  logic          push;
  logic          pop;

  // The tick fires in the last slot so the new pair is stable for all of the next frame.
  assign frame_tick = en && ((frame_posn & MASK) == MASK);
  assign empty      = (level == '0);
  assign in_ready   = (level != LW'(DEPTH));
  assign push       = in_valid && in_ready;
  assign pop        = frame_tick && !empty;

  always_ff @(posedge ck) begin
    if (push) begin
      mem[wr_ptr] <= {in_left, in_right};
    end
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // An empty tick mutes the output; a pair pushed on that same edge waits for the next tick.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      left     <= '0;
      right    <= '0;
      underrun <= 1'b0;
    end else begin
      underrun <= frame_tick && empty;
      if (pop) begin
        {left, right} <= mem[rd_ptr];
      end else if (frame_tick) begin
        left  <= '0;
        right <= '0;
      end
    end
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      underrun_count <= '0;
    end else if (clr_count) begin
      underrun_count <= '0;
    end else if (frame_tick && empty && (underrun_count != 8'hFF)) begin
      underrun_count <= underrun_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_i2s_tx_fifo.sv
// Self-checking bench for i2s_tx_fifo: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_i2s_tx_fifo;

  localparam int DEPTH = 8;
  localparam logic [5:0] MASK64 = 6'h3F;

  logic        ck = 1'b0;
  logic        rst_n;
  logic        en;
  logic [5:0]  frame_posn;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_left;
  logic [15:0] in_right;
  logic [15:0] left;
  logic [15:0] right;
  logic [3:0]  level;
  logic        underrun;
  logic [7:0]  underrun_count;
  logic        clr_count;

  logic        en32;
  logic [5:0]  fp32;
  logic        in_ready32;
  logic [15:0] left32;
  logic [15:0] right32;
  logic [5:0]  level32;
  logic        underrun32;
  logic [7:0]  count32;

  int passed = 0;
  int total  = 0;

  logic [31:0] q[$];
  logic [15:0] exp_left;
  logic [15:0] exp_right;
  logic        exp_und;
  logic [7:0]  exp_cnt;

  always #5 ck = ~ck;

  i2s_tx_fifo #(.CLOCKS(64), .DEPTH(DEPTH)) dut (
    .ck(ck), .rst_n(rst_n), .en(en), .frame_posn(frame_posn),
    .in_valid(in_valid), .in_ready(in_ready), .in_left(in_left), .in_right(in_right),
    .left(left), .right(right), .level(level), .underrun(underrun),
    .underrun_count(underrun_count), .clr_count(clr_count)
  );

  i2s_tx_fifo #(.CLOCKS(32), .DEPTH(32)) dut32 (
    .ck(ck), .rst_n(rst_n), .en(en32), .frame_posn(fp32),
    .in_valid(1'b0), .in_ready(in_ready32), .in_left(16'h0), .in_right(16'h0),
    .left(left32), .right(right32), .level(level32), .underrun(underrun32),
    .underrun_count(count32), .clr_count(1'b0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // The model pops before it pushes, so an empty tick never sees a same-edge push.
  task automatic applyStimulus(input logic v, input logic [15:0] l, input logic [15:0] r,
                               input logic e, input logic [5:0] fp, input logic clr);
    bit do_push;
    bit do_tick;
    in_valid   = v;
    in_left    = l;
    in_right   = r;
    en         = e;
    frame_posn = fp;
    clr_count  = clr;
    do_push = v && (q.size() != DEPTH);
    do_tick = e && ((fp & MASK64) == MASK64);
    @(posedge ck);
    #1;
    exp_und = 1'b0;
    if (do_tick) begin
      if (q.size() > 0) begin
        {exp_left, exp_right} = q.pop_front();
      end else begin
        exp_left  = 16'h0;
        exp_right = 16'h0;
        exp_und   = 1'b1;
        if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
      end
    end
    if (clr) exp_cnt = 8'h0;
    if (do_push) q.push_back({l, r});
  endtask

  task automatic idle();
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 6'h00, 1'b0);
  endtask

  task automatic tick();
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, MASK64, 1'b0);
  endtask

  task automatic checkOutput(input string tag);
    check({tag, ".left"},     32'(left),           32'(exp_left));
    check({tag, ".right"},    32'(right),          32'(exp_right));
    check({tag, ".level"},    32'(level),          32'(q.size()));
    check({tag, ".in_ready"}, 32'(in_ready),       32'(q.size() != DEPTH));
    check({tag, ".underrun"}, 32'(underrun),       32'(exp_und));
    check({tag, ".count"},    32'(underrun_count), 32'(exp_cnt));
  endtask

  task automatic model_reset();
    q.delete();
    exp_left  = 16'h0;
    exp_right = 16'h0;
    exp_und   = 1'b0;
    exp_cnt   = 8'h0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [15:0] rl;
    logic [15:0] rr;
    logic [5:0]  rfp;
    logic [31:0] first_pair;

    rst_n = 1'b0;
    en32  = 1'b0;
    fp32  = 6'h0;
    model_reset();
    in_valid = 1'b0; in_left = '0; in_right = '0; en = 1'b0; frame_posn = '0; clr_count = 1'b0;
    repeat (2) @(posedge ck);
    #1;
    checkOutput("reset");
    rst_n = 1'b1;

    // Single pair through one tick.
    applyStimulus(1'b1, 16'h1111, 16'h2222, 1'b0, MASK64, 1'b0);
    checkOutput("push1");
    tick();
    checkOutput("tick1");

    // Fill to full; extra valid and a tick-with-valid must not sneak a push in.
    for (int i = 0; i < DEPTH; i++) begin
      rl = 16'($urandom);
      rr = 16'($urandom);
      if (i == 0) first_pair = {rl, rr};
      applyStimulus(1'b1, rl, rr, 1'b0, 6'h00, 1'b0);
    end
    checkOutput("full");
    applyStimulus(1'b1, 16'hDEAD, 16'hBEEF, 1'b0, 6'h00, 1'b0);
    checkOutput("full_reject");
    applyStimulus(1'b1, 16'hCAFE, 16'hF00D, 1'b1, MASK64, 1'b0);
    checkOutput("full_pop");
    check("full_pop.first", {16'(left), 16'(right)}, first_pair);

    // en low suppresses the tick even in the last slot.
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, MASK64, 1'b0);
    checkOutput("en_low");
    while (q.size() > 0) tick();
    checkOutput("drained");

    // Empty ticks: single pulse, then saturation, then clear beats increment.
    tick();
    checkOutput("under1");
    idle();
    checkOutput("under1_off");
    for (int i = 0; i < 300; i++) tick();
    checkOutput("under_sat");
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, MASK64, 1'b1);
    checkOutput("clr_prio");

    // Push coincident with an empty tick is stored, not bypassed.
    applyStimulus(1'b1, 16'hA5A5, 16'h5A5A, 1'b1, MASK64, 1'b0);
    checkOutput("empty_push");
    tick();
    checkOutput("empty_push_next");

    // CLOCKS=32 instance: only the low five frame bits matter.
    en32 = 1'b1; fp32 = 6'h3F;
    idle();
    check("c32.tick3F", 32'(underrun32), 32'd1);
    en32 = 1'b0; fp32 = 6'h1F;
    idle();
    check("c32.en_low", 32'(underrun32), 32'd0);
    en32 = 1'b1; fp32 = 6'h20;
    idle();
    check("c32.slot0", 32'(underrun32), 32'd0);
    en32 = 1'b1; fp32 = 6'h1F;
    idle();
    check("c32.tick1F", 32'(underrun32), 32'd1);
    check("c32.count", 32'(count32), 32'd2);
    en32 = 1'b0;

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rl  = 16'($urandom);
      rr  = 16'($urandom);
      rfp = ($urandom_range(3) == 0) ? MASK64 : 6'($urandom);
      applyStimulus(1'($urandom_range(1)), rl, rr, ($urandom_range(3) != 0), rfp,
                    ($urandom_range(31) == 0));
      checkOutput("rand");
    end

    // Reset mid-frame discards stored pairs.
    while (q.size() > 0) tick();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'(i + 1), 16'(i + 8), 1'b0, 6'h05, 1'b0);
    tick();
    rst_n = 1'b0;
    #2;
    model_reset();
    checkOutput("async_reset");
    in_valid = 1'b0; en = 1'b0;
    repeat (2) @(posedge ck);
    #1;
    rst_n = 1'b1;
    tick();
    checkOutput("post_reset_tick");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
